// File: rtl/stm32_bus_master_if.sv
// Command, response and nibble-bus signals between a host controller and
// the stm32_bus_master initiator.
interface stm32_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_code;
    logic [21:0] cfg_freq;
    logic        cfg_preamp;
    logic        cfg_tx;
    logic [15:0] tx_i;
    logic [15:0] tx_q;
    logic [15:0] test_nib;
    logic        DATA_SYNC;
    logic [3:0]  DATA_OUT;
    logic [3:0]  DATA_IN;
    logic        rsp_valid;
    logic [15:0] rsp_i;
    logic [15:0] rsp_q;
    logic        rsp_otr;
    logic [15:0] rsp_test;
    logic        busy;
    logic        err_cmd;

    modport master (
        input  cmd_valid, cmd_code, cfg_freq, cfg_preamp, cfg_tx,
        input  tx_i, tx_q, test_nib, DATA_IN,
        output cmd_ready, DATA_SYNC, DATA_OUT, rsp_valid,
        output rsp_i, rsp_q, rsp_otr, rsp_test, busy, err_cmd
    );

    modport slave (
        output cmd_valid, cmd_code, cfg_freq, cfg_preamp, cfg_tx,
        output tx_i, tx_q, test_nib, DATA_IN,
        input  cmd_ready, DATA_SYNC, DATA_OUT, rsp_valid,
        input  rsp_i, rsp_q, rsp_otr, rsp_test, busy, err_cmd
    );
endinterface

// File: rtl/stm32_bus_master.sv
// Initiator for the 4-bit nibble bus to the stm32_interface responder.
// Frames one command at a time as a DATA_SYNC strobe plus payload nibbles
// and collects response nibbles into the response fields.
module stm32_bus_master #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned RSP_LAT    = 1
) (
    input  logic               clk_in,
    input  logic               reset,
    stm32_bus_master_if.master bus
);
    localparam int unsigned TW = $clog2(RSP_LAT + 16) + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEND,
        RECV,
        DONE,
        GAP
    } state_t;

    state_t state, state_nxt, after_frame;

    logic [3:0]    code_q;
    logic [3:0]    n_pay;
    logic [3:0]    n_rsp;
    logic [31:0]   pay_q;
    logic [31:0]   rx_sh;
    logic [31:0]   rx_nxt;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gap_cnt;
    logic          err_q;
    logic [15:0]   rsp_i_q;
    logic [15:0]   rsp_q_q;
    logic          rsp_otr_q;
    logic [15:0]   rsp_test_q;

    logic          supported;
    logic [3:0]    dec_pay;
    logic [3:0]    dec_rsp;
    logic [31:0]   dec_word;

    logic [TW-1:0] first_smp;
    logic [TW-1:0] last_smp;
    logic [TW-1:0] last_pay;
    logic          sample_en;
    logic          last_sample;

    // tcnt holds the cycle index T relative to acceptance (T1 = SYNC cycle),
    // so payload and response windows are fixed offsets from it.
    assign first_smp   = TW'(2 + RSP_LAT);
    assign last_smp    = first_smp + TW'(n_rsp) - TW'(1);
    assign last_pay    = TW'(n_pay) + TW'(1);
    assign sample_en   = (state == SEND || state == RECV) && (n_rsp != 4'd0) &&
                         (tcnt >= first_smp) && (tcnt <= last_smp);
    assign last_sample = sample_en && (tcnt == last_smp);
    assign rx_nxt      = {rx_sh[27:0], bus.DATA_IN};

    // Decode the incoming command into payload/response lengths and payload word.
    always_comb begin
        supported = 1'b1;
        dec_pay   = 4'd0;
        dec_rsp   = 4'd0;
        dec_word  = '0;
        case (bus.cmd_code)
            4'd1: begin
                dec_pay  = 4'd7;
                dec_word = {bus.cfg_tx, bus.cfg_preamp, 2'b00, 2'b00, bus.cfg_freq, 4'h0};
            end
            4'd2: dec_rsp = 4'd1;
            4'd3: begin
                dec_pay  = 4'd8;
                dec_word = {bus.tx_q, bus.tx_i};
            end
            4'd4: dec_rsp = 4'd8;
            4'd5, 4'd6: ;
            4'd10: begin
                dec_pay  = 4'd4;
                dec_rsp  = 4'd4;
                dec_word = {bus.test_nib, 16'h0000};
            end
            default: supported = 1'b0;
        endcase
    end

    // Next-state logic and bus/handshake outputs.
    always_comb begin
        after_frame   = (GAP_CYCLES == 0) ? IDLE : GAP;
        state_nxt     = state;
        bus.cmd_ready = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.DATA_SYNC = (state == SYNC);
        bus.DATA_OUT  = 4'h0;
        bus.rsp_valid = (state == DONE);
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = supported ? SYNC : after_frame;
                end
            end
            SYNC: begin
                bus.DATA_OUT = code_q;
                if (n_pay != 4'd0) begin
                    state_nxt = SEND;
                end else if (n_rsp != 4'd0) begin
                    state_nxt = RECV;
                end else begin
                    state_nxt = after_frame;
                end
            end
            SEND: begin
                bus.DATA_OUT = pay_q[31:28];
                if (tcnt == last_pay) begin
                    state_nxt = (n_rsp != 4'd0) ? RECV : after_frame;
                end
            end
            RECV: begin
                if (last_sample) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = after_frame;
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, payload shifter, response capture and counters.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            code_q     <= '0;
            n_pay      <= '0;
            n_rsp      <= '0;
            pay_q      <= '0;
            rx_sh      <= '0;
            tcnt       <= '0;
            gap_cnt    <= '0;
            err_q      <= 1'b0;
            rsp_i_q    <= '0;
            rsp_q_q    <= '0;
            rsp_otr_q  <= 1'b0;
            rsp_test_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (state == IDLE && bus.cmd_valid) begin
                code_q <= bus.cmd_code;
                n_pay  <= dec_pay;
                n_rsp  <= dec_rsp;
                pay_q  <= dec_word;
                tcnt   <= TW'(1);
                err_q  <= ~supported;
            end else if (state != IDLE && state != GAP) begin
                tcnt <= tcnt + TW'(1);
            end
            if (state == SEND) begin
                pay_q <= pay_q << 4;
            end
            if (sample_en) begin
                rx_sh <= rx_nxt;
            end
            // Fields are written from the shift value including the final
            // nibble so they are already valid in the rsp_valid cycle.
            if (last_sample) begin
                case (code_q)
                    4'd2: rsp_otr_q <= bus.DATA_IN[0];
                    4'd4: begin
                        rsp_q_q <= rx_nxt[31:16];
                        rsp_i_q <= rx_nxt[15:0];
                    end
                    4'd10: rsp_test_q <= rx_nxt[15:0];
                    default: ;
                endcase
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    assign bus.err_cmd  = err_q;
    assign bus.rsp_i    = rsp_i_q;
    assign bus.rsp_q    = rsp_q_q;
    assign bus.rsp_otr  = rsp_otr_q;
    assign bus.rsp_test = rsp_test_q;
endmodule

// File: tb/tb_stm32_bus_master.sv
// Self-checking bench for stm32_bus_master: the bench plays the responder,
// drives DATA_IN on a fixed schedule and scoreboards the response fields.
module tb_stm32_bus_master;
    localparam int GAP   = 1;
    localparam int LAT   = 1;
    localparam int FIRST = 2 + LAT;
    localparam int MAXT  = 24;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        otr;
        logic [15:0] test;
    } rsp_t;

    logic clk_in = 1'b0;
    logic reset;

    stm32_bus_master_if bus ();

    stm32_bus_master #(.GAP_CYCLES(GAP), .RSP_LAT(LAT)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    rsp_t        exp_q[$];
    logic [15:0] m_i;
    logic [15:0] m_q;
    logic [15:0] m_test;
    logic        m_otr;
    logic        audio_en;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic       sync_l  [0:MAXT];
    logic [3:0] out_l   [0:MAXT];
    logic       rv_l    [0:MAXT];
    logic       busy_l  [0:MAXT];
    logic       ready_l [0:MAXT];
    logic       err_l   [0:MAXT];
    logic [3:0] rnib    [0:7];
    int         rn;

    // Scoreboard: every rsp_valid pops one expected response.
    always @(negedge clk_in) begin : sb
        rsp_t e;
        if (bus.rsp_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp_valid: rsp_valid=1 required 0 (no response pending)");
            end else begin
                e = exp_q.pop_front();
                if ({bus.rsp_i, bus.rsp_q, bus.rsp_otr, bus.rsp_test} !== e) begin
                    n_fail++;
                    $display("FAIL rsp_fields: i=%h q=%h otr=%b test=%h required i=%h q=%h otr=%b test=%h",
                             bus.rsp_i, bus.rsp_q, bus.rsp_otr, bus.rsp_test, e.i, e.q, e.otr, e.test);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_rsp(input logic [31:0] w, input int n);
        rn = n;
        for (int k = 0; k < 8; k++) rnib[k] = w[31-4*k -: 4];
    endtask

    // Issue one command, then log the bus for ncyc cycles while playing responder.
    task automatic run_frame(input logic [3:0] code, input int ncyc, input int rst_at);
        int waited = 0;
        bus.DATA_IN = 4'hE;
        @(negedge clk_in);
        while (bus.cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk_in);
            waited++;
        end
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout: cmd_ready=%b required 1", bus.cmd_ready);
        end
        bus.cmd_code  = code;
        bus.cmd_valid = 1'b1;
        ready_l[0] = bus.cmd_ready;
        @(posedge clk_in);
        #1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_code   = 4'hF;
        bus.cfg_freq   = ~bus.cfg_freq;
        bus.cfg_preamp = ~bus.cfg_preamp;
        bus.cfg_tx     = ~bus.cfg_tx;
        bus.tx_i       = ~bus.tx_i;
        bus.tx_q       = ~bus.tx_q;
        bus.test_nib   = ~bus.test_nib;
        for (int t = 1; t <= ncyc; t++) begin
            if (t >= FIRST && t < FIRST + rn) bus.DATA_IN = rnib[t-FIRST];
            else if (t < FIRST)               bus.DATA_IN = 4'hE;
            else                              bus.DATA_IN = 4'hA;
            reset = (t == rst_at);
            @(negedge clk_in);
            sync_l[t]  = bus.DATA_SYNC;
            out_l[t]   = bus.DATA_OUT;
            rv_l[t]    = bus.rsp_valid;
            busy_l[t]  = bus.busy;
            ready_l[t] = bus.cmd_ready;
            err_l[t]   = bus.err_cmd;
            @(posedge clk_in);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_code   = 4'h0;
        bus.cfg_freq   = '0;
        bus.cfg_preamp = 1'b0;
        bus.cfg_tx     = 1'b0;
        bus.tx_i       = '0;
        bus.tx_q       = '0;
        bus.test_nib   = '0;
        bus.DATA_IN    = 4'h0;
        m_i = '0; m_q = '0; m_test = '0; m_otr = 1'b0; audio_en = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        n_tests++;
        if ({bus.cmd_ready, bus.busy, bus.DATA_SYNC, bus.DATA_OUT, bus.rsp_valid, bus.err_cmd} !== 9'b1_0_0_0000_0_0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready,busy,sync,out,rv,err=%b required 100000000",
                     {bus.cmd_ready, bus.busy, bus.DATA_SYNC, bus.DATA_OUT, bus.rsp_valid, bus.err_cmd});
        end
        n_tests++;
        if ({bus.rsp_i, bus.rsp_q, bus.rsp_otr, bus.rsp_test} !== 49'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: i=%h q=%h otr=%b test=%h required all 0",
                     bus.rsp_i, bus.rsp_q, bus.rsp_otr, bus.rsp_test);
        end
        @(posedge clk_in);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        set_rsp(32'h1357_9BDF, 8);
        run_frame(4'd4, 8, 5);
        n_tests++;
        if ({sync_l[6], busy_l[6], ready_l[6]} !== 3'b001) begin
            n_fail++;
            $display("FAIL midreset_state: sync,busy,ready=%b required 001", {sync_l[6], busy_l[6], ready_l[6]});
        end
        n_tests++;
        if ({bus.rsp_i, bus.rsp_q} !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_fields: i=%h q=%h required 0000 0000", bus.rsp_i, bus.rsp_q);
        end
        m_i = '0; m_q = '0; m_test = '0; m_otr = 1'b0;
        set_rsp({16'h7F00, 16'h00FF}, 8);
        m_i = 16'h00FF;
        m_q = 16'h7F00;
        exp_q.push_back('{i: m_i, q: m_q, otr: m_otr, test: m_test});
        run_frame(4'd4, 14, 0);
        n_tests++;
        if (rv_l[11] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_next_rv: rsp_valid@T11=%b required 1", rv_l[11]);
        end
    endtask

    task automatic test_get_params();
        logic [31:0] w;
        logic [21:0] f;
        bus.cfg_freq   = 22'h097777;
        bus.cfg_preamp = 1'b1;
        bus.cfg_tx     = 1'b0;
        set_rsp(32'h0, 0);
        run_frame(4'd1, 11, 0);
        w = 32'h1409_7777;
        for (int t = 1; t <= 8; t++) begin
            n_tests++;
            if (out_l[t] !== w[31-4*(t-1) -: 4]) begin
                n_fail++;
                $display("FAIL get_params_nib%0d: DATA_OUT=%h required %h", t, out_l[t], w[31-4*(t-1) -: 4]);
            end
        end
        for (int t = 1; t <= 10; t++) begin
            n_tests++;
            if (sync_l[t] !== (t == 1)) begin
                n_fail++;
                $display("FAIL get_params_sync%0d: DATA_SYNC=%b required %b", t, sync_l[t], (t == 1));
            end
        end
        f = {out_l[3][1:0], out_l[4], out_l[5], out_l[6], out_l[7], out_l[8]};
        n_tests++;
        if (f !== 22'd620407 || out_l[2][2] !== 1'b1 || out_l[2][3] !== 1'b0) begin
            n_fail++;
            $display("FAIL get_params_decode: freq=%0d preamp=%b rx=%b required 620407 1 1", f, out_l[2][2], ~out_l[2][3]);
        end
        n_tests++;
        if ({out_l[9], busy_l[9], ready_l[9], ready_l[9+GAP]} !== 7'b0000_1_0_1) begin
            n_fail++;
            $display("FAIL get_params_gap: out,busy,ready,ready_next=%b required 0000101",
                     {out_l[9], busy_l[9], ready_l[9], ready_l[9+GAP]});
        end
    endtask

    task automatic test_rx_iq();
        bus.DATA_IN = 4'hE;
        set_rsp({16'h1234, 16'h8001}, 8);
        m_i = 16'h8001;
        m_q = 16'h1234;
        exp_q.push_back('{i: m_i, q: m_q, otr: m_otr, test: m_test});
        run_frame(4'd4, 13, 0);
        n_tests++;
        if ({rv_l[10], rv_l[11], rv_l[12]} !== 3'b010) begin
            n_fail++;
            $display("FAIL rx_iq_rv_timing: rv@T10..T12=%b required 010", {rv_l[10], rv_l[11], rv_l[12]});
        end
        n_tests++;
        if ({ready_l[11+GAP], ready_l[12+GAP]} !== 2'b01) begin
            n_fail++;
            $display("FAIL rx_iq_ready: ready@T%0d,T%0d=%b required 01", 11+GAP, 12+GAP, {ready_l[11+GAP], ready_l[12+GAP]});
        end
        n_tests++;
        if ({sync_l[1], out_l[1], sync_l[2], out_l[2], out_l[6]} !== 14'b1_0100_0_0000_0000) begin
            n_fail++;
            $display("FAIL rx_iq_bus: sync1,out1,sync2,out2,out6=%b required 10100000000000",
                     {sync_l[1], out_l[1], sync_l[2], out_l[2], out_l[6]});
        end
        set_rsp({16'h4567, 16'hC0DE}, 8);
        m_i = 16'hC0DE;
        m_q = 16'h4567;
        exp_q.push_back('{i: m_i, q: m_q, otr: m_otr, test: m_test});
        run_frame(4'd4, 12, 0);
        n_tests++;
        if (rv_l[11] !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_iq_b2b_rv: rsp_valid@T11=%b required 1", rv_l[11]);
        end
    endtask

    task automatic test_tx_iq();
        logic [15:0] ri;
        logic [15:0] rq;
        logic        any_rv;
        bus.tx_i = 16'hA5C3;
        bus.tx_q = 16'h0F1E;
        set_rsp(32'h0, 0);
        run_frame(4'd3, 11, 0);
        rq = {out_l[2], out_l[3], out_l[4], out_l[5]};
        ri = {out_l[6], out_l[7], out_l[8], out_l[9]};
        n_tests++;
        if (ri !== 16'hA5C3 || rq !== 16'h0F1E) begin
            n_fail++;
            $display("FAIL tx_iq_payload: TX_I=%h TX_Q=%h required A5C3 0F1E", ri, rq);
        end
        any_rv = 1'b0;
        for (int t = 1; t <= 11; t++) any_rv |= rv_l[t];
        n_tests++;
        if (any_rv !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_iq_no_rv: rsp_valid seen=%b required 0", any_rv);
        end
        n_tests++;
        if ({out_l[10], busy_l[10], ready_l[10+GAP]} !== 6'b0000_1_1) begin
            n_fail++;
            $display("FAIL tx_iq_gap: out,busy,ready=%b required 000011", {out_l[10], busy_l[10], ready_l[10+GAP]});
        end
    endtask

    task automatic test_test_bus();
        logic [15:0] sent;
        bus.test_nib = 16'h9C36;
        set_rsp({16'h9C36, 16'h0000}, 4);
        m_test = 16'h9C36;
        exp_q.push_back('{i: m_i, q: m_q, otr: m_otr, test: m_test});
        run_frame(4'd10, 9, 0);
        sent = {out_l[2], out_l[3], out_l[4], out_l[5]};
        n_tests++;
        if (sent !== 16'h9C36 || out_l[1] !== 4'hA) begin
            n_fail++;
            $display("FAIL test_bus_payload: code=%h nibbles=%h required A 9C36", out_l[1], sent);
        end
        n_tests++;
        if ({rv_l[6], rv_l[7], ready_l[7+GAP+1]} !== 3'b011) begin
            n_fail++;
            $display("FAIL test_bus_timing: rv6,rv7,ready=%b required 011", {rv_l[6], rv_l[7], ready_l[7+GAP+1]});
        end
    endtask

    task automatic test_send_params();
        set_rsp(32'h1000_0000, 1);
        m_otr = 1'b1;
        exp_q.push_back('{i: m_i, q: m_q, otr: m_otr, test: m_test});
        run_frame(4'd2, 6, 0);
        n_tests++;
        if ({rv_l[3], rv_l[4], out_l[2], ready_l[4+GAP+1]} !== 7'b01_0000_1) begin
            n_fail++;
            $display("FAIL send_params_timing: rv3,rv4,out2,ready=%b required 0100001",
                     {rv_l[3], rv_l[4], out_l[2], ready_l[4+GAP+1]});
        end
    endtask

    task automatic test_bad_code();
        logic any_sync;
        set_rsp(32'h0, 0);
        run_frame(4'd7, 3, 0);
        any_sync = 1'b0;
        for (int t = 1; t <= 3; t++) any_sync |= sync_l[t];
        n_tests++;
        if ({err_l[1], err_l[2], any_sync} !== 3'b100) begin
            n_fail++;
            $display("FAIL bad_code_err: err1,err2,sync=%b required 100", {err_l[1], err_l[2], any_sync});
        end
        n_tests++;
        if ({busy_l[1], ready_l[1], ready_l[1+GAP]} !== 3'b101) begin
            n_fail++;
            $display("FAIL bad_code_ready: busy1,ready1,ready_after=%b required 101", {busy_l[1], ready_l[1], ready_l[1+GAP]});
        end
    endtask

    task automatic test_audio_pll();
        logic [1:0] seen;
        set_rsp(32'h0, 0);
        run_frame(4'd5, 3, 0);
        if (sync_l[1] === 1'b1 && out_l[1] === 4'd5) audio_en = 1'b1;
        seen[1] = audio_en;
        n_tests++;
        if ({busy_l[2], ready_l[2+GAP]} !== 2'b11) begin
            n_fail++;
            $display("FAIL audio_on_gap: busy2,ready=%b required 11", {busy_l[2], ready_l[2+GAP]});
        end
        run_frame(4'd6, 3, 0);
        if (sync_l[1] === 1'b1 && out_l[1] === 4'd6) audio_en = 1'b0;
        seen[0] = audio_en;
        n_tests++;
        if (seen !== 2'b10) begin
            n_fail++;
            $display("FAIL audio_toggle: audio_clk_en after 5,6=%b required 10", seen);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_get_params();
        test_rx_iq();
        test_tx_iq();
        test_test_bus();
        test_send_params();
        test_bad_code();
        test_audio_pll();
        repeat (3) @(posedge clk_in);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
